// File: rtl/dp_ram_mailbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dp_ram_mailbox
//  Description : Host/arith shared-memory mailbox built from NUM_BANKS
//                independent dual-port RAM banks. The host side is an
//                Avalon-MM slave with a windowed DATA register, a
//                programmable pointer stride and a read prefetch that is
//                guarded by waitrequest. The arith side has one flat
//                read/write port per bank. Both sides share one clock.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    avalon_clock  in   1                     single clock for host, arith, RAMs
//    reset         in   1                     synchronous, active-high
//    read          in   1                     Avalon read strobe
//    write         in   1                     Avalon write strobe
//    address       in   3                     register index
//    writedata     in   32                    Avalon write data
//    readdata      out  32                    Avalon read data, registered
//    waitrequest   out  1                     stall on DATA read without prefetch
//    we_arith      in   NUM_BANKS             per-bank arith write enable
//    addr_arith    in   NUM_BANKS*ADDR_WIDTH  bank b at [b*ADDR_WIDTH +: ADDR_WIDTH]
//    data_arith    in   NUM_BANKS*DATA_WIDTH  arith write data, same packing
//    q_arith       out  NUM_BANKS*DATA_WIDTH  arith read data, 1 cycle, write-first
//  Register map
//    0 DATA  1 PTR  2 CTRL([3:0] SEL, [8] AINC)  3 ID  4 STRIDE
//    5 STATUS([0] WRAP, [1] COLL, [2] PF_VALID; any write clears WRAP/COLL)
//    6,7 read as zero
// ============================================================================
module dp_ram_mailbox #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_BANKS  = 2,
  parameter int ID         = 1
) (
  input  logic                             avalon_clock,
  input  logic                             reset,
  input  logic                             read,
  input  logic                             write,
  input  logic [2:0]                       address,
  input  logic [31:0]                      writedata,
  output logic [31:0]                      readdata,
  output logic                             waitrequest,
  input  logic [NUM_BANKS-1:0]             we_arith,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  addr_arith,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  data_arith,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  q_arith
);

  localparam logic [2:0] c_REG_DATA   = 3'd0;
  localparam logic [2:0] c_REG_PTR    = 3'd1;
  localparam logic [2:0] c_REG_CTRL   = 3'd2;
  localparam logic [2:0] c_REG_ID     = 3'd3;
  localparam logic [2:0] c_REG_STRIDE = 3'd4;
  localparam logic [2:0] c_REG_STATUS = 3'd5;

  typedef enum logic [1:0] {
    ST_INVAL = 2'd0,  // prefetch stale: RAM read issued at this edge
    ST_FETCH = 2'd1,  // RAM output being captured into r_pf_data
    ST_VALID = 2'd2   // r_pf_data holds bank[SEL][PTR]
  } pf_state_t;

  pf_state_t r_state;
  pf_state_t w_state_nxt;

  // Host-visible registers
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [3:0]            r_sel;
  logic                  r_ainc;
  logic                  r_wrap;
  logic                  r_coll;
  logic [DATA_WIDTH-1:0] r_pf_data;
  logic [31:0]           r_readdata;

  // Host write pipeline: the RAM is written one cycle after acceptance
  logic                  r_hw_en;
  logic [3:0]            r_hw_sel;
  logic [ADDR_WIDTH-1:0] r_hw_addr;
  logic [DATA_WIDTH-1:0] r_hw_data;

  // Per-bank status vectors and flattened host-port read data
  logic [NUM_BANKS-1:0]            w_bank_is_sel;
  logic [NUM_BANKS-1:0]            w_arith_hit_ptr;
  logic [NUM_BANKS-1:0]            w_ram_coll;
  logic [NUM_BANKS*DATA_WIDTH-1:0] w_host_q;
  logic [DATA_WIDTH-1:0]           w_sel_q;

  // Host decode
  logic                  w_rd;
  logic                  w_data_wr;
  logic                  w_data_rd_ok;
  logic                  w_ptr_wr;
  logic                  w_sel_ok;
  logic                  w_sel_wr;
  logic                  w_ptr_step;
  logic                  w_arith_hit_sel;
  logic                  w_acc_coll;
  logic                  w_inval;
  logic                  w_carry;
  logic [ADDR_WIDTH-1:0] w_ptr_sum;
  logic [31:0]           w_ptr_ext;
  logic [31:0]           w_stride_ext;
  logic [31:0]           w_pf_ext;

  // --------------------------------------------------------------------------
  // RAM banks
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] r_hq;
    logic [ADDR_WIDTH-1:0] w_aaddr;
    logic [DATA_WIDTH-1:0] w_adata;
    logic                  w_host_we;

    assign w_aaddr = addr_arith[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_adata = data_arith[b*DATA_WIDTH +: DATA_WIDTH];

    assign w_bank_is_sel[b]   = (r_sel == 4'(b));
    assign w_arith_hit_ptr[b] = w_bank_is_sel[b] && we_arith[b] && (w_aaddr == r_ptr);
    // A delayed host write landing on the word the arith port writes in the
    // same cycle is dropped so the arith data survives.
    assign w_ram_coll[b] = r_hw_en && (r_hw_sel == 4'(b)) && we_arith[b] &&
                           (w_aaddr == r_hw_addr);
    assign w_host_we     = r_hw_en && (r_hw_sel == 4'(b)) && !w_ram_coll[b];

    // Contents are not reset; arith writes proceed even while reset is high.
    always_ff @(posedge avalon_clock) begin
      if (we_arith[b]) begin
        r_mem[w_aaddr] <= w_adata;
      end
      if (w_host_we) begin
        r_mem[r_hw_addr] <= r_hw_data;
      end
    end

    // Arith read port: write-first on its own port; a host write to the same
    // word in the same cycle is not visible here (old data).
    always_ff @(posedge avalon_clock) begin
      if (reset) begin
        r_q <= '0;
      end else if (we_arith[b]) begin
        r_q <= w_adata;
      end else begin
        r_q <= r_mem[w_aaddr];
      end
    end

    // Host prefetch read, issued only in ST_INVAL. A host write committing to
    // the very word being prefetched is forwarded (AINC=0 case).
    always_ff @(posedge avalon_clock) begin
      if (r_state == ST_INVAL) begin
        if (w_host_we && (r_hw_addr == r_ptr)) begin
          r_hq <= r_hw_data;
        end else begin
          r_hq <= r_mem[r_ptr];
        end
      end
    end

    assign w_host_q[b*DATA_WIDTH +: DATA_WIDTH] = r_hq;
    assign q_arith[b*DATA_WIDTH +: DATA_WIDTH]  = r_q;
  end

  always_comb begin
    w_sel_q = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_bank_is_sel[b]) begin
        w_sel_q = w_host_q[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Host decode
  // --------------------------------------------------------------------------
  // A simultaneous read and write is treated as a write only.
  assign w_rd            = read && !write;
  assign w_data_wr       = write && (address == c_REG_DATA);
  assign w_data_rd_ok    = w_rd && (address == c_REG_DATA) && (r_state == ST_VALID);
  assign w_ptr_wr        = write && (address == c_REG_PTR);
  assign w_sel_ok        = ({1'b0, writedata[3:0]} < 5'(NUM_BANKS));
  assign w_sel_wr        = write && (address == c_REG_CTRL) && w_sel_ok;
  assign w_ptr_step      = r_ainc && (w_data_wr || w_data_rd_ok);
  assign w_arith_hit_sel = |w_arith_hit_ptr;
  // Host DATA write targets {SEL,PTR}; an arith write there in the same
  // cycle wins and the host word is never queued.
  assign w_acc_coll      = w_data_wr && w_arith_hit_sel;
  assign {w_carry, w_ptr_sum} = {1'b0, r_ptr} + {1'b0, r_stride};

  assign w_inval = w_data_wr || w_data_rd_ok || w_ptr_wr || w_sel_wr || w_arith_hit_sel;

  assign waitrequest = !reset && w_rd && (address == c_REG_DATA) && (r_state != ST_VALID);
  assign readdata    = r_readdata;

  always_comb begin
    w_ptr_ext                   = '0;
    w_stride_ext                = '0;
    w_pf_ext                    = '0;
    w_ptr_ext[ADDR_WIDTH-1:0]    = r_ptr;
    w_stride_ext[ADDR_WIDTH-1:0] = r_stride;
    w_pf_ext[DATA_WIDTH-1:0]     = r_pf_data;
  end

  // --------------------------------------------------------------------------
  // Prefetch FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge avalon_clock) begin
    if (reset) begin
      r_state <= ST_INVAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INVAL: w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_VALID;
      ST_VALID: w_state_nxt = ST_VALID;
      default:  w_state_nxt = ST_INVAL;
    endcase
    // Any event that could make the prefetch stale restarts it.
    if (w_inval) begin
      w_state_nxt = ST_INVAL;
    end
  end

  always_ff @(posedge avalon_clock) begin
    if (reset) begin
      r_pf_data <= '0;
    end else if (r_state == ST_FETCH) begin
      r_pf_data <= w_sel_q;
    end
  end

  // --------------------------------------------------------------------------
  // Host registers
  // --------------------------------------------------------------------------
  always_ff @(posedge avalon_clock) begin
    if (reset) begin
      r_ptr      <= '0;
      r_stride   <= ADDR_WIDTH'(1);
      r_sel      <= '0;
      r_ainc     <= 1'b1;
      r_wrap     <= 1'b0;
      r_coll     <= 1'b0;
      r_hw_en    <= 1'b0;
      r_hw_sel   <= '0;
      r_hw_addr  <= '0;
      r_hw_data  <= '0;
      r_readdata <= '0;
    end else begin
      r_hw_en   <= w_data_wr && !w_acc_coll;
      r_hw_sel  <= r_sel;
      r_hw_addr <= r_ptr;
      r_hw_data <= writedata[DATA_WIDTH-1:0];

      if (w_ptr_wr) begin
        r_ptr <= writedata[ADDR_WIDTH-1:0];
      end else if (w_ptr_step) begin
        r_ptr <= w_ptr_sum;
      end

      if (write && (address == c_REG_CTRL)) begin
        if (w_sel_ok) begin
          r_sel <= writedata[3:0];
        end
        r_ainc <= writedata[8];
      end

      if (write && (address == c_REG_STRIDE)) begin
        r_stride <= writedata[ADDR_WIDTH-1:0];
      end

      // Clear first so a same-cycle set event is not lost.
      if (write && (address == c_REG_STATUS)) begin
        r_wrap <= 1'b0;
        r_coll <= 1'b0;
      end
      if (w_ptr_step && w_carry) begin
        r_wrap <= 1'b1;
      end
      if (w_acc_coll || (|w_ram_coll)) begin
        r_coll <= 1'b1;
      end

      if (w_rd) begin
        case (address)
          c_REG_DATA: begin
            if (r_state == ST_VALID) begin
              r_readdata <= w_pf_ext;
            end
          end
          c_REG_PTR:    r_readdata <= w_ptr_ext;
          c_REG_CTRL:   r_readdata <= {23'd0, r_ainc, 4'd0, r_sel};
          c_REG_ID:     r_readdata <= 32'(ID);
          c_REG_STRIDE: r_readdata <= w_stride_ext;
          c_REG_STATUS: r_readdata <= {29'd0, (r_state == ST_VALID), r_coll, r_wrap};
          default:      r_readdata <= '0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_mailbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dp_ram_mailbox
//  Description : Directed self-checking bench for dp_ram_mailbox
//                (DATA_WIDTH=32, ADDR_WIDTH=11, NUM_BANKS=2, ID=1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dp_ram_mailbox;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int NB = 2;

  logic              avalon_clock = 1'b0;
  logic              reset;
  logic              read;
  logic              write;
  logic [2:0]        address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              waitrequest;
  logic [NB-1:0]     we_arith;
  logic [NB*AW-1:0]  addr_arith;
  logic [NB*DW-1:0]  data_arith;
  logic [NB*DW-1:0]  q_arith;

  int checks = 0;
  int errors = 0;

  always #5 avalon_clock = ~avalon_clock;

  dp_ram_mailbox #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_BANKS  (NB),
    .ID         (1)
  ) dut (
    .avalon_clock (avalon_clock),
    .reset        (reset),
    .read         (read),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .waitrequest  (waitrequest),
    .we_arith     (we_arith),
    .addr_arith   (addr_arith),
    .data_arith   (data_arith),
    .q_arith      (q_arith)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic av_write(input logic [2:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(posedge avalon_clock);
    #1;
    write = 1'b0;
  endtask

  task automatic av_read(input logic [2:0] a, output logic [31:0] d, output int stalls);
    address = a;
    read    = 1'b1;
    stalls  = 0;
    @(negedge avalon_clock);
    while (waitrequest && stalls < 16) begin
      stalls++;
      @(negedge avalon_clock);
    end
    @(posedge avalon_clock);
    #1;
    read = 1'b0;
    d    = readdata;
  endtask

  task automatic set_arith(input int bank, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic we);
    addr_arith[bank*AW +: AW] = a;
    data_arith[bank*DW +: DW] = d;
    we_arith[bank]            = we;
  endtask

  initial begin
    logic [31:0] d;
    int          s;
    int          polls;

    reset      = 1'b1;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    we_arith   = '0;
    addr_arith = '0;
    data_arith = '0;

    repeat (2) @(posedge avalon_clock);
    #1;
    check("reset_readdata", readdata, 0);
    check("reset_waitrequest", waitrequest, 0);
    check("reset_q_arith", q_arith, 0);
    reset = 1'b0;

    // 1: ID, prefetch comes up, reset register values
    av_read(3'd3, d, s);
    check("id_value", d, 1);
    check("id_no_stall", s, 0);
    polls = 0;
    do begin
      av_read(3'd5, d, s);
      polls++;
    end while (!d[2] && polls < 6);
    check("pf_valid_within_3", (polls <= 3), 1);
    check("status_after_reset", d, 32'h4);
    av_read(3'd1, d, s);
    check("reset_ptr", d, 0);
    av_read(3'd2, d, s);
    check("reset_ctrl", d, 32'h100);
    av_read(3'd4, d, s);
    check("reset_stride", d, 1);
    av_write(3'd7, 32'hDEAD_BEEF);
    av_read(3'd6, d, s);
    check("reg6_zero", d, 0);
    av_read(3'd7, d, s);
    check("reg7_zero", d, 0);

    // 2: sequential writes and prefetched reads
    av_write(3'd1, 5);
    av_write(3'd0, 32'hA);
    av_write(3'd0, 32'hB);
    av_write(3'd0, 32'hC);
    av_write(3'd1, 5);
    av_read(3'd0, d, s);
    check("data_rd0", d, 32'hA);
    check("data_rd0_stall", (s <= 2), 1);
    av_read(3'd0, d, s);
    check("data_rd1", d, 32'hB);
    check("data_rd1_stall", (s <= 2), 1);
    av_read(3'd0, d, s);
    check("data_rd2", d, 32'hC);
    av_read(3'd1, d, s);
    check("ptr_after_reads", d, 8);
    set_arith(0, 5, 0, 1'b0);
    @(posedge avalon_clock);
    #1;
    check("arith_sees_host_word", q_arith[31:0], 32'hA);

    // 3: stride and pointer wrap
    av_write(3'd4, 4);
    av_write(3'd1, 2044);
    av_write(3'd0, 32'h111);
    av_write(3'd0, 32'h222);
    av_read(3'd1, d, s);
    check("ptr_wrapped", d, 4);
    av_read(3'd5, d, s);
    check("status_wrap", d[0], 1);
    av_write(3'd1, 2044);
    av_read(3'd0, d, s);
    check("word_2044", d, 32'h111);
    av_read(3'd0, d, s);
    check("word_0", d, 32'h222);
    av_write(3'd5, 0);
    av_read(3'd5, d, s);
    check("wrap_cleared", d[1:0], 0);
    av_write(3'd4, 1);

    // 4: arith write invalidates the host prefetch
    av_write(3'd2, 32'h101);
    av_write(3'd1, 7);
    polls = 0;
    do begin
      av_read(3'd5, d, s);
      polls++;
    end while (!d[2] && polls < 6);
    check("pf_valid_bank1", d[2], 1);
    set_arith(1, 7, 32'h55, 1'b1);
    @(posedge avalon_clock);
    #1;
    set_arith(1, 7, 0, 1'b0);
    check("arith_write_first", q_arith[63:32], 32'h55);
    av_read(3'd0, d, s);
    check("inval_readdata", d, 32'h55);
    check("inval_stall_le2", (s <= 2), 1);

    // 5: host/arith collision on bank0[3]
    av_write(3'd2, 32'h100);
    av_write(3'd1, 3);
    set_arith(0, 3, 32'h22, 1'b1);
    av_write(3'd0, 32'h11);
    set_arith(0, 3, 0, 1'b0);
    av_read(3'd5, d, s);
    check("coll_set", d[1], 1);
    av_read(3'd1, d, s);
    check("coll_ptr_inc", d, 4);
    check("coll_arith_q", q_arith[31:0], 32'h22);
    av_write(3'd1, 3);
    av_read(3'd0, d, s);
    check("coll_host_rd", d, 32'h22);
    av_write(3'd5, 0);
    av_read(3'd5, d, s);
    check("coll_cleared", d[1], 0);

    // 6: out-of-range SEL ignored
    av_write(3'd2, 32'h101);
    av_write(3'd2, 32'h10F);
    av_read(3'd2, d, s);
    check("sel_ignored", d, 32'h101);

    // Reset during a stalled DATA read; arith write during reset
    av_write(3'd1, 9);
    address = 3'd0;
    read    = 1'b1;
    @(negedge avalon_clock);
    check("stall_before_reset", waitrequest, 1);
    reset = 1'b1;
    set_arith(0, 100, 32'h77, 1'b1);
    #1;
    check("wr_drop_in_reset", waitrequest, 0);
    @(posedge avalon_clock);
    #1;
    read = 1'b0;
    set_arith(0, 100, 0, 1'b0);
    check("readdata_in_reset", readdata, 0);
    check("q_arith_in_reset", q_arith, 0);
    @(posedge avalon_clock);
    #1;
    reset = 1'b0;
    av_read(3'd1, d, s);
    check("ptr_after_mid_reset", d, 0);
    av_read(3'd2, d, s);
    check("ctrl_after_mid_reset", d, 32'h100);
    set_arith(0, 5, 0, 1'b0);
    @(posedge avalon_clock);
    #1;
    check("ram_kept", q_arith[31:0], 32'hA);
    av_write(3'd1, 100);
    av_read(3'd0, d, s);
    check("arith_wr_in_reset", d, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
